// File: rtl/line_pixel_writer_pkg.sv
// Shared definitions for the line rasterizer back end: FSM states, common
// logic constants and the framebuffer address width helper.
package line_pixel_writer_pkg;

    typedef enum logic {
        STATE_IDLE  = 1'b0,
        STATE_CLEAR = 1'b1
    } state_e;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
    localparam logic ZERO  = 1'b0;
    localparam logic ONE   = 1'b1;

    function automatic int fb_addr_width(input int width_bits);
        return 2 * width_bits;
    endfunction

endpackage

// File: rtl/line_pixel_writer_if.sv
// Pixel stream from the rasterizer plus the framebuffer write port.
// The rasterizer side is the master; the pixel writer is the slave.
interface line_pixel_writer_if #(
    parameter int WIDTH_BITS = 6,
    parameter int COLOR_BITS = 8
);
    import line_pixel_writer_pkg::*;

    localparam int ADDR_W = fb_addr_width(WIDTH_BITS);

    logic                         valid;
    logic signed [WIDTH_BITS:0]   x;
    logic signed [WIDTH_BITS:0]   y;
    logic        [COLOR_BITS-1:0] color_in;
    logic                         fb_we;
    logic        [ADDR_W-1:0]     fb_addr;
    logic        [COLOR_BITS-1:0] fb_data;

    modport master (
        output valid, x, y, color_in,
        input  fb_we, fb_addr, fb_data
    );

    modport slave (
        input  valid, x, y, color_in,
        output fb_we, fb_addr, fb_data
    );

endinterface

// File: rtl/line_pixel_writer_sat_counter.sv
// Statistics counter that increments on enable and sticks at all-ones.
module sat_counter #(
    parameter int COUNT_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    output logic [COUNT_BITS-1:0] count
);

    logic [COUNT_BITS-1:0] count_d;
    logic [COUNT_BITS-1:0] count_q;

    function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] v);
        return (&v) ? v : v + COUNT_BITS'(1);
    endfunction

    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = sat_inc(count_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/line_pixel_writer.sv
// Clips rasterizer pixels to the framebuffer, drives its single write port
// through a two-stage pipeline, and fills the buffer on request in idle slots.
module line_pixel_writer
    import line_pixel_writer_pkg::*;
#(
    parameter int WIDTH_BITS = 6,
    parameter int COLOR_BITS = 8,
    parameter int COUNT_BITS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    line_pixel_writer_if.slave    bus,
    input  logic                  clear_start,
    input  logic [COLOR_BITS-1:0] clear_color,
    output logic                  busy,
    output logic [COUNT_BITS-1:0] pixel_count,
    output logic [COUNT_BITS-1:0] clip_count
);

    localparam int ADDR_W = fb_addr_width(WIDTH_BITS);
    localparam logic [ADDR_W-1:0] LAST_PTR = '1;

    state_e                  state_d, state_q;
    logic [ADDR_W-1:0]       clr_ptr_d, clr_ptr_q;
    logic [COLOR_BITS-1:0]   clr_color_d, clr_color_q;
    logic                    vld_p1_d, vld_p1_q;
    logic [ADDR_W-1:0]       addr_p1_d, addr_p1_q;
    logic [COLOR_BITS-1:0]   color_p1_d, color_p1_q;
    logic                    fb_we_d, fb_we_q;
    logic [ADDR_W-1:0]       fb_addr_d, fb_addr_q;
    logic [COLOR_BITS-1:0]   fb_data_d, fb_data_q;
    logic                    in_range;
    logic                    clip_inc;

    // Sign bits clear means in range; the coordinate width bounds the top end.
    assign in_range = ~bus.x[WIDTH_BITS] & ~bus.y[WIDTH_BITS];
    assign clip_inc = bus.valid & ~in_range;

    // Stage p1: clip and address formation
    always_comb begin
        vld_p1_d   = bus.valid & in_range;
        addr_p1_d  = addr_p1_q;
        color_p1_d = color_p1_q;
        if (bus.valid) begin
            addr_p1_d  = {bus.y[WIDTH_BITS-1:0], bus.x[WIDTH_BITS-1:0]};
            color_p1_d = bus.color_in;
        end
    end

    // Stage p2: write-port arbitration, pixels pre-empt the clear engine
    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        clr_color_d = clr_color_q;
        fb_we_d     = FALSE;
        fb_addr_d   = fb_addr_q;
        fb_data_d   = fb_data_q;
        if (vld_p1_q) begin
            fb_we_d   = TRUE;
            fb_addr_d = addr_p1_q;
            fb_data_d = color_p1_q;
        end else if (state_q == STATE_CLEAR) begin
            fb_we_d   = TRUE;
            fb_addr_d = clr_ptr_q;
            fb_data_d = clr_color_q;
            clr_ptr_d = clr_ptr_q + ADDR_W'(ONE);
            if (clr_ptr_q == LAST_PTR) begin
                state_d = STATE_IDLE;
            end
        end
        if (state_q == STATE_IDLE && clear_start) begin
            state_d     = STATE_CLEAR;
            clr_ptr_d   = '0;
            clr_color_d = clear_color;
        end
    end

    always_ff @(posedge clk) begin
        addr_p1_q  <= addr_p1_d;
        color_p1_q <= color_p1_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= STATE_IDLE;
            clr_ptr_q   <= '0;
            clr_color_q <= '0;
            vld_p1_q    <= ZERO;
            fb_we_q     <= ZERO;
            fb_addr_q   <= '0;
            fb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            clr_color_q <= clr_color_d;
            vld_p1_q    <= vld_p1_d;
            fb_we_q     <= fb_we_d;
            fb_addr_q   <= fb_addr_d;
            fb_data_q   <= fb_data_d;
        end
    end

    sat_counter #(.COUNT_BITS(COUNT_BITS)) u_pixel_cnt (
        .clk   (clk),
        .rst   (reset),
        .inc   (vld_p1_q),
        .count (pixel_count)
    );

    sat_counter #(.COUNT_BITS(COUNT_BITS)) u_clip_cnt (
        .clk   (clk),
        .rst   (reset),
        .inc   (clip_inc),
        .count (clip_count)
    );

    assign bus.fb_we   = fb_we_q;
    assign bus.fb_addr = fb_addr_q;
    assign bus.fb_data = fb_data_q;
    assign busy        = (state_q == STATE_CLEAR);

endmodule

// File: tb/tb_line_pixel_writer.sv
// Directed bench for line_pixel_writer: single-pixel vector table, a pixel
// stream, plain and pre-empted clears, and asynchronous reset mid-clear.
module tb_line_pixel_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear_start;
    logic [7:0]  clear_color;
    logic        busy;
    logic [15:0] pixel_count;
    logic [15:0] clip_count;

    int errors = 0;
    int checks = 0;

    line_pixel_writer_if #(.WIDTH_BITS(6), .COLOR_BITS(8)) bus ();

    line_pixel_writer #(.WIDTH_BITS(6), .COLOR_BITS(8), .COUNT_BITS(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .clear_start (clear_start),
        .clear_color (clear_color),
        .busy        (busy),
        .pixel_count (pixel_count),
        .clip_count  (clip_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         x;
        int         y;
        logic [7:0] color;
        logic       exp_we;
        logic [11:0] exp_addr;
        logic [7:0] exp_data;
        int         exp_pix;
        int         exp_clip;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one clear to completion, optionally injecting three pixels once the
    // clear pointer reaches inject_at, and a stray clear_start at cycle 500.
    task automatic run_clear(input logic [7:0] col, input int inject_at,
                             output int busy_cyc, output int clr_writes,
                             output int pix_seen, output int bad, output int cyc);
        int pix_sent;
        busy_cyc   = 0;
        clr_writes = 0;
        pix_seen   = 0;
        bad        = 0;
        cyc        = 0;
        pix_sent   = 0;
        bus.valid   = 1'b0;
        clear_color = col;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        while ((busy || bus.fb_we) && cyc < 6000) begin
            if (busy) busy_cyc++;
            if (bus.fb_we) begin
                if (bus.fb_data == 8'h77) begin
                    if (bus.fb_addr != 12'(20 * 64 + 10 + pix_seen)) bad++;
                    pix_seen++;
                end else begin
                    if (bus.fb_addr != 12'(clr_writes) || bus.fb_data != col) bad++;
                    clr_writes++;
                end
            end
            bus.valid   = 1'b0;
            clear_start = 1'b0;
            if (inject_at >= 0 && clr_writes >= inject_at && pix_sent < 3) begin
                bus.valid    = 1'b1;
                bus.x        = 7'(10 + pix_sent);
                bus.y        = 7'(20);
                bus.color_in = 8'h77;
                pix_sent++;
            end
            if (cyc == 500) begin
                clear_start = 1'b1;
                clear_color = 8'h22;
            end
            tick();
            cyc++;
        end
        bus.valid   = 1'b0;
        clear_start = 1'b0;
    endtask

    initial begin
        int busy_cyc, clr_writes, pix_seen, bad, cyc, stray;

        vecs[0] = '{3,   2,   8'h5A, 1'b1, 12'h083, 8'h5A, 1, 0};
        vecs[1] = '{-1,  5,   8'hAA, 1'b0, 12'h083, 8'h5A, 1, 1};
        vecs[2] = '{5,   -1,  8'hAB, 1'b0, 12'h083, 8'h5A, 1, 2};
        vecs[3] = '{-64, -64, 8'hAC, 1'b0, 12'h083, 8'h5A, 1, 3};
        vecs[4] = '{63,  63,  8'hFF, 1'b1, 12'hFFF, 8'hFF, 2, 3};
        vecs[5] = '{0,   0,   8'h01, 1'b1, 12'h000, 8'h01, 3, 3};

        reset        = 1'b1;
        bus.valid    = 1'b0;
        bus.x        = '0;
        bus.y        = '0;
        bus.color_in = '0;
        clear_start  = 1'b0;
        clear_color  = '0;
        repeat (3) tick();
        check("reset_fb_we", bus.fb_we, 0);
        check("reset_fb_addr", bus.fb_addr, 0);
        check("reset_fb_data", bus.fb_data, 0);
        check("reset_busy", busy, 0);
        check("reset_pixel_count", pixel_count, 0);
        check("reset_clip_count", clip_count, 0);
        reset = 1'b0;
        repeat (2) tick();
        check("idle_fb_we", bus.fb_we, 0);

        foreach (vecs[i]) begin
            bus.x        = 7'(vecs[i].x);
            bus.y        = 7'(vecs[i].y);
            bus.color_in = vecs[i].color;
            bus.valid    = 1'b1;
            tick();
            bus.valid = 1'b0;
            check($sformatf("vec%0d_early_we", i), bus.fb_we, 0);
            tick();
            check($sformatf("vec%0d_we", i), bus.fb_we, vecs[i].exp_we);
            check($sformatf("vec%0d_addr", i), bus.fb_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_data", i), bus.fb_data, vecs[i].exp_data);
            check($sformatf("vec%0d_pixel_count", i), pixel_count, vecs[i].exp_pix);
            check($sformatf("vec%0d_clip_count", i), clip_count, vecs[i].exp_clip);
        end

        // Back-to-back stream (0,0)..(9,9)
        for (int k = 0; k < 12; k++) begin
            bus.valid    = (k < 10);
            bus.x        = 7'(k);
            bus.y        = 7'(k);
            bus.color_in = 8'(8'h30 + k);
            tick();
            if (k >= 1 && k <= 10) begin
                check($sformatf("stream%0d_we", k - 1), bus.fb_we, 1);
                check($sformatf("stream%0d_addr", k - 1), bus.fb_addr, (k - 1) * 65);
                check($sformatf("stream%0d_data", k - 1), bus.fb_data, 8'h30 + k - 1);
            end else if (k == 11) begin
                check("stream_end_we", bus.fb_we, 0);
            end
        end
        bus.valid = 1'b0;
        check("stream_pixel_count", pixel_count, 13);

        run_clear(8'h11, -1, busy_cyc, clr_writes, pix_seen, bad, cyc);
        check("clear_timeout", cyc < 6000, 1);
        check("clear_busy_cycles", busy_cyc, 4096);
        check("clear_writes", clr_writes, 4096);
        check("clear_addr_data_errors", bad, 0);
        check("clear_done_busy", busy, 0);
        check("clear_pixel_count", pixel_count, 13);

        run_clear(8'h11, 100, busy_cyc, clr_writes, pix_seen, bad, cyc);
        check("preempt_timeout", cyc < 6000, 1);
        check("preempt_busy_cycles", busy_cyc, 4099);
        check("preempt_clear_writes", clr_writes, 4096);
        check("preempt_pixel_writes", pix_seen, 3);
        check("preempt_addr_data_errors", bad, 0);
        check("preempt_pixel_count", pixel_count, 16);
        check("preempt_clip_count", clip_count, 3);

        // Asynchronous reset in the middle of a clear
        clear_color = 8'h44;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        cyc = 0;
        while (!(bus.fb_we && bus.fb_addr == 12'd2000) && cyc < 3000) begin
            tick();
            cyc++;
        end
        check("reset_reach_2000", cyc < 3000, 1);
        #2 reset = 1'b1;
        #1;
        check("async_fb_we", bus.fb_we, 0);
        check("async_busy", busy, 0);
        check("async_fb_addr", bus.fb_addr, 0);
        check("async_pixel_count", pixel_count, 0);
        check("async_clip_count", clip_count, 0);
        tick();
        reset = 1'b0;
        stray = 0;
        repeat (20) begin
            tick();
            if (bus.fb_we || busy) stray++;
        end
        check("post_reset_idle", stray, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/line_pixel_writer.md
Name: line_pixel_writer

Overview:
- Downstream stage of the line rasterizer. Consumes its per-cycle pixel stream (valid, x, y, color) with no backpressure.
- Clips each pixel to the square framebuffer 2^WIDTH_BITS x 2^WIDTH_BITS and converts it to a linear address. Drives a single framebuffer write port.
- Also provides a framebuffer clear engine. The clear engine yields to rasterizer pixels every cycle, so no pixel is ever lost.

Parameters:
- WIDTH_BITS, 6, log2 of framebuffer side; coordinate ports are WIDTH_BITS+1 bits signed.
- COLOR_BITS, 8, pixel colour width.
- COUNT_BITS, 16, width of the statistics counters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- valid  in  1  pixel strobe from rasterizer
- x  in  WIDTH_BITS+1 signed  pixel x
- y  in  WIDTH_BITS+1 signed  pixel y
- color_in  in  COLOR_BITS  pixel colour
- clear_start  in  1  one-cycle request to fill the framebuffer
- clear_color  in  COLOR_BITS  fill colour, sampled with clear_start
- fb_we  out  1  framebuffer write enable
- fb_addr  out  2*WIDTH_BITS  write address, {y, x} low bits
- fb_data  out  COLOR_BITS  write data
- busy  out  1  clear in progress
- pixel_count  out  COUNT_BITS  pixels written from the stream
- clip_count  out  COUNT_BITS  pixels discarded by clipping

Behaviour:
- Reset (async, active-high) forces all of the following to 0 / IDLE: fb_we, fb_addr, fb_data, busy, both counters, pipeline valids, clear pointer, latched clear colour, state. Reset asserted mid-clear abandons the clear; it does not resume after reset.
- Clip rule: a pixel is in range iff x[WIDTH_BITS]==0 and y[WIDTH_BITS]==0, i.e. both coordinates are non-negative. No upper compare is needed, since the coordinate range is -2^W .. 2^W-1.
- Address = {y[WIDTH_BITS-1:0], x[WIDTH_BITS-1:0]}.
- Stage 1, registered on the cycle valid is high:
  - p1_valid = valid & in_range; p1_addr and p1_color are captured.
  - If valid & !in_range, clip_count increments, saturating at all-ones.
- Stage 2, output registers:
  - If p1_valid: fb_we=1, fb_addr=p1_addr, fb_data=p1_color, and pixel_count increments (saturating).
  - Else if state==CLEAR: fb_we=1, fb_addr=clr_ptr, fb_data=clr_color, and clr_ptr increments.
  - Else fb_we=0; fb_addr and fb_data hold their previous values.
- Latency: a pixel on valid at cycle N appears on fb_we at cycle N+2. One pixel per cycle is sustained indefinitely.
- FSM states:
  - IDLE: clear_start=1 goes to CLEAR; clr_ptr=0 and clr_color=clear_color are latched.
  - CLEAR: on a cycle where a clear write is issued with clr_ptr == 2^(2*WIDTH_BITS)-1, go to IDLE. Cycles pre-empted by a pixel leave clr_ptr unchanged.
- busy = (state==CLEAR). It rises the cycle after clear_start and falls the cycle after the last clear write.
- clear_start while in CLEAR is ignored; colour and pointer are unchanged.
- A clear with no pixel traffic takes exactly 2^(2*WIDTH_BITS) write cycles. Each pre-empting pixel extends the clear by one cycle.
- Ordering: a clear may overwrite pixels drawn earlier in the same clear window. Software sequences clear before drawing by waiting for busy==0. No hazard check is performed.
- Counters only ever increment; they are cleared by reset only.

Decomposition:
- Shared package holds:
  - state constants STATE_IDLE=0 and STATE_CLEAR=1;
  - TRUE/FALSE/ZERO/ONE constants shared with the rasterizer;
  - a function for the framebuffer address width, 2*WIDTH_BITS.
- One natural sub-module: sat_counter (COUNT_BITS wide, with increment enable and saturation), instantiated twice, once for pixel_count and once for clip_count.
- Clip logic, pipeline and FSM stay in line_pixel_writer.

Test Plan (WIDTH_BITS=6, COLOR_BITS=8):
- Single pixel x=3, y=2, color 0x5A at cycle N -> at N+2, fb_we=1, fb_addr=0x083, fb_data=0x5A; pixel_count=1.
- Pixels (-1,5), (5,-1), (-64,-64), each one cycle -> no fb_we; clip_count=3; pixel_count unchanged.
- Back-to-back stream of 10 in-range pixels, (0,0)..(9,9) -> 10 consecutive fb_we cycles at addresses 0x000, 0x041 ... 0x249, in order.
- clear_start with clear_color 0x11, no traffic -> busy high for 4096 cycles; fb_addr steps 0x000..0xFFF, all with data 0x11; a second clear_start mid-clear is ignored.
- During a clear, inject 3 pixels at clr_ptr≈100 -> the pixel writes appear at their own addresses; clear resumes at the held pointer with no address skipped; busy lasts 4099 cycles.
- Assert reset at clear pointer 2000 (asynchronously, mid-cycle) -> fb_we, busy and the counters drop to 0 immediately. After release, the block is idle with no writes until a new clear_start.
